// File: rtl/xalu_iter.sv
// xalu_iter: multi-cycle multiply/divide unit owning the architectural HI/LO
// registers. Multiplies finish after MUL_CYCLES cycles; divides run a 32-step
// restoring iteration followed by one sign-fixup cycle. mthi/mtlo are
// single-cycle writes. A flush aborts whatever is in flight without touching
// HI/LO.
module xalu_iter #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_STEPS  = 32
) (
  input  logic        Clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [3:0] OP_MULT  = 4'd0;
  localparam logic [3:0] OP_MULTU = 4'd1;
  localparam logic [3:0] OP_DIV   = 4'd2;
  localparam logic [3:0] OP_DIVU  = 4'd3;
  localparam logic [3:0] OP_MADD  = 4'd4;
  localparam logic [3:0] OP_MADDU = 4'd5;
  localparam logic [3:0] OP_MSUB  = 4'd6;
  localparam logic [3:0] OP_MSUBU = 4'd7;
  localparam logic [3:0] OP_MTHI  = 4'd8;
  localparam logic [3:0] OP_MTLO  = 4'd9;
  localparam logic [3:0] OP_MUL   = 4'd10;

  localparam logic [4:0] MUL_CNT_INIT = 5'(MUL_CYCLES - 1);
  localparam logic [4:0] DIV_CNT_INIT = 5'(DIV_STEPS - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MUL     = 2'd1,
    S_DIV     = 2'd2,
    S_DIV_FIX = 2'd3
  } state_t;

  function automatic logic op_is_mul(input logic [3:0] o);
    return (o == OP_MULT) || (o == OP_MULTU) || (o == OP_MADD) ||
           (o == OP_MADDU) || (o == OP_MSUB) || (o == OP_MSUBU) ||
           (o == OP_MUL);
  endfunction

  function automatic logic op_is_div(input logic [3:0] o);
    return (o == OP_DIV) || (o == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input logic [3:0] o);
    return (o == OP_MULT) || (o == OP_DIV) || (o == OP_MADD) ||
           (o == OP_MSUB) || (o == OP_MUL);
  endfunction

  state_t      state_reg, state_next;
  logic [3:0]  op_reg;
  // a_reg holds the multiplicand, or the dividend that is shifted out MSB
  // first while quotient bits are shifted in at the LSB.
  logic [31:0] a_reg;
  logic [31:0] b_reg;
  logic [31:0] rem_reg;
  logic [4:0]  cnt_reg;
  logic        neg_q_reg;
  logic        neg_r_reg;
  logic [31:0] hi_reg, lo_reg;
  logic        busy_reg;

  logic        accept;
  logic        hi_we, lo_we;
  logic [31:0] hi_din, lo_din;
  logic        busy_next;

  logic [63:0] mul_ax, mul_bx, product, mul_result;
  logic [32:0] rem_shift, rem_diff;
  logic        q_bit;
  logic [31:0] rem_step;

  assign accept = (state_reg == S_IDLE) && start && !flush;
  assign busy   = busy_reg;
  assign hi     = hi_reg;
  assign lo     = lo_reg;

  // Multiply datapath: operands extended to 64 bits so one product serves
  // both signed and unsigned forms (mod 2^64).
  always_comb begin
    mul_ax  = op_is_signed(op_reg) ? {{32{a_reg[31]}}, a_reg} : {32'd0, a_reg};
    mul_bx  = op_is_signed(op_reg) ? {{32{b_reg[31]}}, b_reg} : {32'd0, b_reg};
    product = mul_ax * mul_bx;
    unique case (op_reg)
      OP_MADD, OP_MADDU: mul_result = {hi_reg, lo_reg} + product;
      OP_MSUB, OP_MSUBU: mul_result = {hi_reg, lo_reg} - product;
      default:           mul_result = product;
    endcase
  end

  // One restoring divide step: bring in the next dividend bit, subtract the
  // divisor when that does not borrow. A zero divisor always "fits", which
  // yields an all-ones quotient and the dividend as remainder.
  always_comb begin
    rem_shift = {rem_reg, a_reg[31]};
    rem_diff  = rem_shift - {1'b0, b_reg};
    q_bit     = ~rem_diff[32];
    rem_step  = q_bit ? rem_diff[31:0] : rem_shift[31:0];
  end

  // State register.
  always_ff @(posedge Clk) begin
    if (reset) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; flush returns to IDLE from anywhere.
  always_comb begin
    state_next = state_reg;
    if (flush) begin
      state_next = S_IDLE;
    end else begin
      unique case (state_reg)
        S_IDLE: begin
          if (start && op_is_mul(op)) begin
            state_next = S_MUL;
          end else if (start && op_is_div(op)) begin
            state_next = S_DIV;
          end
        end
        S_MUL:     if (cnt_reg == 5'd0) state_next = S_IDLE;
        S_DIV:     if (cnt_reg == 5'd0) state_next = S_DIV_FIX;
        S_DIV_FIX: state_next = S_IDLE;
      endcase
    end
  end

  // Output logic: HI/LO write enables and data, and the registered busy.
  always_comb begin
    hi_we     = 1'b0;
    lo_we     = 1'b0;
    hi_din    = hi_reg;
    lo_din    = lo_reg;
    busy_next = (state_next != S_IDLE);
    if (!flush) begin
      unique case (state_reg)
        S_IDLE: begin
          if (start && op == OP_MTHI) begin
            hi_we  = 1'b1;
            hi_din = a;
          end
          if (start && op == OP_MTLO) begin
            lo_we  = 1'b1;
            lo_din = a;
          end
        end
        S_MUL: begin
          if (cnt_reg == 5'd0) begin
            hi_we  = 1'b1;
            lo_we  = 1'b1;
            hi_din = mul_result[63:32];
            lo_din = mul_result[31:0];
          end
        end
        S_DIV: begin
        end
        S_DIV_FIX: begin
          hi_we  = 1'b1;
          lo_we  = 1'b1;
          lo_din = neg_q_reg ? (32'd0 - a_reg) : a_reg;
          hi_din = neg_r_reg ? (32'd0 - rem_reg) : rem_reg;
        end
      endcase
    end
  end

  // Datapath registers: operand capture, iteration, HI/LO and busy.
  always_ff @(posedge Clk) begin
    if (reset) begin
      op_reg    <= 4'd0;
      a_reg     <= 32'd0;
      b_reg     <= 32'd0;
      rem_reg   <= 32'd0;
      cnt_reg   <= 5'd0;
      neg_q_reg <= 1'b0;
      neg_r_reg <= 1'b0;
      hi_reg    <= 32'd0;
      lo_reg    <= 32'd0;
      busy_reg  <= 1'b0;
    end else begin
      busy_reg <= busy_next;
      if (hi_we) hi_reg <= hi_din;
      if (lo_we) lo_reg <= lo_din;
      if (accept && op_is_mul(op)) begin
        op_reg  <= op;
        a_reg   <= a;
        b_reg   <= b;
        cnt_reg <= MUL_CNT_INIT;
      end else if (accept && op_is_div(op)) begin
        op_reg    <= op;
        a_reg     <= (op_is_signed(op) && a[31]) ? (32'd0 - a) : a;
        b_reg     <= (op_is_signed(op) && b[31]) ? (32'd0 - b) : b;
        rem_reg   <= 32'd0;
        cnt_reg   <= DIV_CNT_INIT;
        neg_q_reg <= op_is_signed(op) && (a[31] ^ b[31]);
        neg_r_reg <= op_is_signed(op) && a[31];
      end else if (!flush && state_reg == S_MUL) begin
        if (cnt_reg != 5'd0) cnt_reg <= cnt_reg - 5'd1;
      end else if (!flush && state_reg == S_DIV) begin
        a_reg   <= {a_reg[30:0], q_bit};
        rem_reg <= rem_step;
        if (cnt_reg != 5'd0) cnt_reg <= cnt_reg - 5'd1;
      end
    end
  end

endmodule

// File: tb/tb_xalu_iter.sv
// Scoreboard bench for xalu_iter: the driver pushes the expected HI/LO (and
// busy length) for every multi-cycle op, the monitor pops on each busy fall.
module tb_xalu_iter;
  localparam int MULC = 4;

  logic        Clk = 1'b0;
  logic        reset, start, flush;
  logic [3:0]  op;
  logic [31:0] a, b;
  logic        busy;
  logic [31:0] hi, lo;

  always #5 Clk = ~Clk;

  xalu_iter #(.MUL_CYCLES(MULC)) dut (
    .Clk(Clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .busy(busy), .hi(hi), .lo(lo)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          len;   // expected busy cycles, 0 = do not check
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  int          run_len = 0;
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: plain 64-bit arithmetic from the operation definitions.
  function automatic logic [63:0] ref_result(input logic [3:0] o, input logic [31:0] x,
                                             input logic [31:0] y, input logic [63:0] acc);
    logic [63:0] sp, up;
    logic [31:0] ma, mb, q, r;
    logic        sg;
    sp = 64'(longint'($signed(x)) * longint'($signed(y)));
    up = {32'd0, x} * {32'd0, y};
    case (o)
      4'd0, 4'd10: return sp;
      4'd1:        return up;
      4'd4:        return acc + sp;
      4'd5:        return acc + up;
      4'd6:        return acc - sp;
      4'd7:        return acc - up;
      default: begin
        sg = (o == 4'd2);
        ma = (sg && x[31]) ? -x : x;
        mb = (sg && y[31]) ? -y : y;
        q  = (mb == 0) ? 32'hFFFFFFFF : ma / mb;
        r  = (mb == 0) ? ma : ma % mb;
        if (sg && (x[31] != y[31])) q = -q;
        if (sg && x[31]) r = -r;
        return {r, q};
      end
    endcase
  endfunction

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  // Monitor: a busy fall marks the end of an operation (commit, flush or reset).
  always @(negedge Clk) begin
    if (busy === 1'b1) begin
      run_len++;
    end else if (run_len > 0) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_busy_fall: got busy run %0d expected none", run_len);
      end else begin
        mon_e = sb_q.pop_front();
        chk("result_hi", hi, mon_e.hi);
        chk("result_lo", lo, mon_e.lo);
        if (mon_e.len > 0) chk("busy_len", 32'(run_len), 32'(mon_e.len));
        $display("txn done hi=%h lo=%h busy_cycles=%0d", hi, lo, run_len);
      end
      run_len = 0;
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 100 && busy !== 1'b0; i++) @(negedge Clk);
    if (busy !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL busy_timeout: got busy=%b expected 0 within 100 cycles", busy);
    end
  endtask

  // Issue one op; flush_at in 1..latency flushes on that cycle after issue.
  task automatic run_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                        input int flush_at);
    logic        is_md;
    logic        do_flush;
    logic [63:0] r;
    int          lat;
    exp_t        e;
    is_md    = (o <= 4'd7) || (o == 4'd10);
    lat      = (o == 4'd2 || o == 4'd3) ? 33 : MULC;
    do_flush = is_md && flush_at > 0 && flush_at <= lat;
    if (is_md) begin
      r = ref_result(o, x, y, {m_hi, m_lo});
      if (do_flush) begin
        e = '{m_hi, m_lo, 0};
      end else begin
        e = '{r[63:32], r[31:0], lat};
        {m_hi, m_lo} = r;
      end
      sb_q.push_back(e);
    end
    @(negedge Clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge Clk);
    start = 1'b0;
    if (!is_md) begin
      if (o == 4'd8) m_hi = x;
      if (o == 4'd9) m_lo = x;
      chk("idle_op_busy", {31'd0, busy}, 32'd0);
      chk("idle_op_hi", hi, m_hi);
      chk("idle_op_lo", lo, m_lo);
      $display("txn op=%0d a=%h hi=%h lo=%h", o, x, hi, lo);
    end else if (do_flush) begin
      repeat (flush_at - 1) @(negedge Clk);
      flush = 1'b1;
      @(negedge Clk);
      flush = 1'b0;
      chk("flush_busy", {31'd0, busy}, 32'd0);
    end
    wait_idle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before 500us");
    $fatal(1);
  end

  initial begin
    exp_t e;
    logic [63:0] r;
    int f;
    logic [3:0] o;
    reset = 1'b1; start = 1'b0; flush = 1'b0; op = 4'd0; a = 32'd0; b = 32'd0;
    repeat (3) @(negedge Clk);
    reset = 1'b0;
    @(negedge Clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);

    run_op(4'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    chk("multu_hi", hi, 32'hFFFFFFFE);
    chk("multu_lo", lo, 32'h00000001);
    run_op(4'd0, 32'hFFFFFFFE, 32'd3, 0);
    chk("mult_lo", lo, 32'hFFFFFFFA);
    run_op(4'd4, 32'd1, 32'd1, 0);
    chk("madd_lo", lo, 32'hFFFFFFFB);
    run_op(4'd7, 32'd2, 32'd3, 0);
    chk("msubu_hi", hi, 32'hFFFFFFFF);
    chk("msubu_lo", lo, 32'hFFFFFFF5);
    run_op(4'd2, 32'hFFFFFFF9, 32'd2, 0);
    chk("div_lo", lo, 32'hFFFFFFFD);
    chk("div_hi", hi, 32'hFFFFFFFF);
    run_op(4'd3, 32'd7, 32'd2, 0);
    run_op(4'd3, 32'h1234, 32'd0, 0);
    chk("divu0_lo", lo, 32'hFFFFFFFF);
    chk("divu0_hi", hi, 32'h1234);
    run_op(4'd2, 32'h80000000, 32'hFFFFFFFF, 0);
    chk("divovf_lo", lo, 32'h80000000);
    chk("divovf_hi", hi, 32'd0);
    run_op(4'd8, 32'hAAAA5555, 32'd0, 0);
    run_op(4'd2, 32'd1000, 32'd3, 10);
    chk("flush_keep_hi", hi, 32'hAAAA5555);
    run_op(4'd1, 32'd5, 32'd6, MULC);    // flush on the commit edge

    // start and flush together: mthi and mult both dropped
    @(negedge Clk);
    start = 1'b1; flush = 1'b1; op = 4'd8; a = 32'h12345678;
    @(negedge Clk);
    op = 4'd0;
    @(negedge Clk);
    start = 1'b0; flush = 1'b0;
    @(negedge Clk);
    chk("startflush_busy", {31'd0, busy}, 32'd0);
    chk("startflush_hi", hi, m_hi);
    $display("txn start+flush hi=%h lo=%h", hi, lo);

    // start while busy is ignored
    r = ref_result(4'd3, 32'd100, 32'd7, {m_hi, m_lo});
    e = '{r[63:32], r[31:0], 33};
    {m_hi, m_lo} = r;
    sb_q.push_back(e);
    @(negedge Clk);
    start = 1'b1; op = 4'd3; a = 32'd100; b = 32'd7;
    @(negedge Clk);
    start = 1'b0;
    repeat (5) @(negedge Clk);
    start = 1'b1; op = 4'd0; a = 32'd3; b = 32'd3;
    @(negedge Clk);
    start = 1'b0;
    wait_idle();
    chk("busy_start_lo", lo, 32'd14);

    // reset in the middle of a divide
    sb_q.push_back('{32'd0, 32'd0, 0});
    @(negedge Clk);
    start = 1'b1; op = 4'd2; a = 32'd77; b = 32'd5;
    @(negedge Clk);
    start = 1'b0;
    repeat (9) @(negedge Clk);
    reset = 1'b1;
    @(negedge Clk);
    reset = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
    chk("reset_mid_busy", {31'd0, busy}, 32'd0);
    chk("reset_mid_hi", hi, 32'd0);
    chk("reset_mid_lo", lo, 32'd0);

    // randomized ops, some flushed
    for (int i = 0; i < 60; i++) begin
      o = 4'($urandom_range(0, 15));
      f = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 33)) : 0;
      run_op(o, rnd32(), rnd32(), f);
    end

    repeat (3) @(negedge Clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
